// File: rtl/ram_port_arbiter.sv
// Round-robin two-requester front end for an 8x16 single-port asynchronous RAM.
// Sequences we/en/address/tri-state data so the write strobe has full setup and hold.
module ram_port_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              a_req_in,
    input  logic              a_we_in,
    input  logic [ADDR_W-1:0] a_addr_in,
    input  logic [DATA_W-1:0] a_wdata_in,
    output logic              a_done_out,
    output logic [DATA_W-1:0] a_rdata_out,
    input  logic              b_req_in,
    input  logic              b_we_in,
    input  logic [ADDR_W-1:0] b_addr_in,
    input  logic [DATA_W-1:0] b_wdata_in,
    output logic              b_done_out,
    output logic [DATA_W-1:0] b_rdata_out,
    output logic              ram_we_out,
    output logic              ram_en_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic              busy_out
);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        W_HOLD,
        R_EN,
        R_CAP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_prio;
    logic              r_owner;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ram_we;
    logic              r_ram_en;
    logic              r_busy;
    logic              r_a_done;
    logic              r_b_done;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              w_grant;
    logic              w_grant_b;
    logic              w_bus_oe;
    logic              w_finishing;

    // r_prio high means B wins a tie; it flips to the loser at every grant.
    always_comb begin
        w_next    = r_state;
        w_grant   = 1'b0;
        w_grant_b = 1'b0;
        case (r_state)
            IDLE: begin
                if (a_req_in || b_req_in) begin
                    w_grant   = 1'b1;
                    w_grant_b = b_req_in && (!a_req_in || r_prio);
                    if (w_grant_b ? b_we_in : a_we_in) begin
                        w_next = W_SETUP;
                    end else begin
                        w_next = R_EN;
                    end
                end
            end
            W_SETUP:  w_next = W_STROBE;
            W_STROBE: w_next = W_HOLD;
            W_HOLD:   w_next = IDLE;
            R_EN:     w_next = R_CAP;
            R_CAP:    w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    assign w_finishing = (r_state == W_HOLD) || (r_state == R_CAP);

    // Strobes are registered from the next state so they line up with the FSM phase.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state   <= IDLE;
            r_prio    <= 1'b0;
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ram_we  <= 1'b0;
            r_ram_en  <= 1'b0;
            r_busy    <= 1'b0;
            r_a_done  <= 1'b0;
            r_b_done  <= 1'b0;
            r_a_rdata <= '0;
            r_b_rdata <= '0;
        end else begin
            r_state  <= w_next;
            r_ram_we <= (w_next == W_STROBE);
            r_ram_en <= (w_next == R_EN) || (w_next == R_CAP);
            r_busy   <= (w_next != IDLE);
            r_a_done <= w_finishing && !r_owner;
            r_b_done <= w_finishing && r_owner;
            if (w_grant) begin
                r_owner <= w_grant_b;
                r_prio  <= !w_grant_b;
                r_addr  <= w_grant_b ? b_addr_in : a_addr_in;
                r_wdata <= w_grant_b ? b_wdata_in : a_wdata_in;
            end
            if (r_state == R_CAP) begin
                if (r_owner) begin
                    r_b_rdata <= ram_data;
                end else begin
                    r_a_rdata <= ram_data;
                end
            end
        end
    end

    assign w_bus_oe = (r_state == W_SETUP) || (r_state == W_STROBE) || (r_state == W_HOLD);
    assign ram_data = w_bus_oe ? r_wdata : {DATA_W{1'bz}};

    assign ram_we_out   = r_ram_we;
    assign ram_en_out   = r_ram_en;
    assign ram_addr_out = r_addr;
    assign busy_out     = r_busy;
    assign a_done_out   = r_a_done;
    assign b_done_out   = r_b_done;
    assign a_rdata_out  = r_a_rdata;
    assign b_rdata_out  = r_b_rdata;

endmodule
